dg_pattern_checker: RTL and testbench

//  Receive-side counterpart of the data generator: consumes the read-back data stream,

---
 rtl/dg_pkg.sv | 42 ++++
 rtl/dg_exp_gen.sv | 64 ++++++
 rtl/dg_pattern_checker.sv | 78 +++++++
 tb/tb_dg_pattern_checker.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dg_pkg.sv
// Shared configuration, pattern modes and sequence helpers for the data
// generator / pattern checker pair.
package dg_pkg;

  localparam int unsigned C_AXI_DATA_WIDTH   = 64;
  localparam int unsigned PATTERN_DATA_WIDTH = 32;
  localparam int unsigned LANES              = C_AXI_DATA_WIDTH / PATTERN_DATA_WIDTH;
  localparam int unsigned BYTES              = C_AXI_DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH          = 16;
  localparam int unsigned CNT_WIDTH          = 8;
  localparam int unsigned ERR_WIDTH          = 16;

  typedef logic [PATTERN_DATA_WIDTH-1:0] elem_t;

  localparam elem_t LFSR_POLY = PATTERN_DATA_WIDTH'(32'h8020_0003);

  typedef enum logic [2:0] {
    FIXED = 3'd0,
    INCR  = 3'd1,
    ROTL  = 3'd2,
    ALT   = 3'd3,
    LFSR  = 3'd4
  } pattern_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CHECK = 2'd2
  } chk_state_t;

  // Right-shifting Galois LFSR: feedback taps applied when the bit shifted out is 1.
  function automatic elem_t lfsr_step(input elem_t e);
    return (e >> 1) ^ (e[0] ? LFSR_POLY : '0);
  endfunction

  function automatic elem_t rotl(input elem_t v, input int unsigned r);
    logic [2*PATTERN_DATA_WIDTH-1:0] t;
    t = {v, v} << r;
    return t[2*PATTERN_DATA_WIDTH-1:PATTERN_DATA_WIDTH];
  endfunction

endpackage

// File: rtl/dg_exp_gen.sv
// Expected-pattern generator: holds mode/seed/sequence position and produces
// the full expected data word for the current beat.
module dg_exp_gen
  import dg_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        init,
  input  logic [2:0]                  mode,
  input  elem_t                       seed,
  input  logic                        adv,
  output logic [C_AXI_DATA_WIDTH-1:0] exp_word_c,
  output logic [IDX_WIDTH-1:0]        beat_idx
);

  pattern_t mode_q;
  elem_t    seed_q;
  elem_t    lfsr_q;
  elem_t    lfsr_next;
  elem_t    lfsr_e;
  elem_t    lane_i;
  elem_t    lane_v;

  // Lane k of the current beat is element beat_idx*LANES + k.
  always_comb begin
    exp_word_c = '0;
    lfsr_e     = lfsr_q;
    lane_i     = '0;
    lane_v     = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_i = PATTERN_DATA_WIDTH'(beat_idx) * PATTERN_DATA_WIDTH'(LANES)
             + PATTERN_DATA_WIDTH'(k);
      case (mode_q)
        INCR:    lane_v = seed_q + lane_i;
        ROTL:    lane_v = rotl(seed_q, lane_i % PATTERN_DATA_WIDTH);
        ALT:     lane_v = lane_i[0] ? ~seed_q : seed_q;
        LFSR:    lane_v = lfsr_e;
        default: lane_v = seed_q;
      endcase
      exp_word_c[k*PATTERN_DATA_WIDTH +: PATTERN_DATA_WIDTH] = lane_v;
      lfsr_e = lfsr_step(lfsr_e);
    end
    lfsr_next = lfsr_e;
  end

  // Sequence state; init has priority over advance. Modes 5-7 collapse to FIXED.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= FIXED;
      seed_q   <= '0;
      lfsr_q   <= PATTERN_DATA_WIDTH'(1);
      beat_idx <= '0;
    end else if (init) begin
      mode_q   <= (mode > 3'd4) ? FIXED : pattern_t'(mode);
      seed_q   <= seed;
      lfsr_q   <= (seed == '0) ? PATTERN_DATA_WIDTH'(1) : seed;
      beat_idx <= '0;
    end else if (adv) begin
      beat_idx <= beat_idx + IDX_WIDTH'(1);
      lfsr_q   <= lfsr_next;
    end
  end

endmodule

// File: rtl/dg_pattern_checker.sv
// Read-data pattern checker: regenerates the expected stream and compares it
// byte-wise under the byte-valid mask, keeping beat/error status.
module dg_pattern_checker
  import dg_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pattern_init,
  input  logic [2:0]                    pattern_mode,
  input  logic [PATTERN_DATA_WIDTH-1:0] pattern_word,
  input  logic [C_AXI_DATA_WIDTH-1:0]   rdata,
  input  logic [BYTES-1:0]              rdata_bvld,
  input  logic                          rdata_vld,
  input  logic                          wrd_cntr_rst,
  output logic [CNT_WIDTH-1:0]          wrd_cntr,
  output logic                          msmatch_err,
  output logic [ERR_WIDTH-1:0]          err_cnt,
  output logic [IDX_WIDTH-1:0]          first_err_idx,
  output logic [C_AXI_DATA_WIDTH-1:0]   exp_data
);

  chk_state_t                  state;
  logic                        accept_c;
  logic                        beat_fail_c;
  logic [C_AXI_DATA_WIDTH-1:0] exp_word_c;
  logic [IDX_WIDTH-1:0]        beat_idx;

  // A beat coinciding with pattern_init is dropped; beats in IDLE are ignored.
  assign accept_c = rdata_vld && !pattern_init && (state != IDLE);

  dg_exp_gen u_exp_gen (
    .clk        (clk),
    .rst        (rst),
    .init       (pattern_init),
    .mode       (pattern_mode),
    .seed       (pattern_word),
    .adv        (accept_c),
    .exp_word_c (exp_word_c),
    .beat_idx   (beat_idx)
  );

  always_comb begin
    beat_fail_c = 1'b0;
    for (int b = 0; b < BYTES; b++) begin
      if (rdata_bvld[b] && (rdata[b*8 +: 8] != exp_word_c[b*8 +: 8])) beat_fail_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wrd_cntr      <= '0;
      msmatch_err   <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      exp_data      <= '0;
    end else if (pattern_init) begin
      state         <= ARMED;
      wrd_cntr      <= '0;
      msmatch_err   <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else begin
      if (wrd_cntr_rst) wrd_cntr <= '0;
      if (accept_c) begin
        state    <= CHECK;
        exp_data <= exp_word_c;
        if (!wrd_cntr_rst) wrd_cntr <= wrd_cntr + CNT_WIDTH'(1);
        if (beat_fail_c) begin
          msmatch_err <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_WIDTH'(1);
          if (err_cnt == '0) first_err_idx <= beat_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_dg_pattern_checker.sv
// Directed self-checking bench for dg_pattern_checker (64-bit data, 32-bit lanes).
module tb_dg_pattern_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        pattern_init;
  logic [2:0]  pattern_mode;
  logic [31:0] pattern_word;
  logic [63:0] rdata;
  logic [7:0]  rdata_bvld;
  logic        rdata_vld;
  logic        wrd_cntr_rst;
  logic [7:0]  wrd_cntr;
  logic        msmatch_err;
  logic [15:0] err_cnt;
  logic [15:0] first_err_idx;
  logic [63:0] exp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dg_pattern_checker dut (
    .clk           (clk),
    .rst           (rst),
    .pattern_init  (pattern_init),
    .pattern_mode  (pattern_mode),
    .pattern_word  (pattern_word),
    .rdata         (rdata),
    .rdata_bvld    (rdata_bvld),
    .rdata_vld     (rdata_vld),
    .wrd_cntr_rst  (wrd_cntr_rst),
    .wrd_cntr      (wrd_cntr),
    .msmatch_err   (msmatch_err),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx),
    .exp_data      (exp_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [2:0] mode, input logic [31:0] seed);
    pattern_init = 1'b1;
    pattern_mode = mode;
    pattern_word = seed;
    tick();
    pattern_init = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] bv);
    rdata      = d;
    rdata_bvld = bv;
    rdata_vld  = 1'b1;
    tick();
    rdata_vld  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pattern_init = 1'b0; pattern_mode = 3'd0; pattern_word = '0;
    rdata = '0; rdata_bvld = '0; rdata_vld = 1'b0; wrd_cntr_rst = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (wrd_cntr !== 8'd0) begin errors++; $display("FAIL reset_wrd_cntr got %h exp 00", wrd_cntr); end
    checks++; if (msmatch_err !== 1'b0) begin errors++; $display("FAIL reset_msmatch got %b exp 0", msmatch_err); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got %h exp 0000", err_cnt); end
    checks++; if (first_err_idx !== 16'd0) begin errors++; $display("FAIL reset_first_idx got %h exp 0000", first_err_idx); end
    checks++; if (exp_data !== 64'd0) begin errors++; $display("FAIL reset_exp_data got %h exp 0", exp_data); end
  endtask

  task automatic test_idle_ignore();
    beat(64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
    beat(64'h1234_5678_9ABC_DEF0, 8'hFF);
    checks++; if (wrd_cntr !== 8'd0) begin errors++; $display("FAIL idle_wrd_cntr got %h exp 00", wrd_cntr); end
    checks++; if (msmatch_err !== 1'b0) begin errors++; $display("FAIL idle_msmatch got %b exp 0", msmatch_err); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL idle_err_cnt got %h exp 0000", err_cnt); end
    checks++; if (exp_data !== 64'd0) begin errors++; $display("FAIL idle_exp_data got %h exp 0", exp_data); end
  endtask

  task automatic test_incr();
    logic [63:0] vec [4];
    vec[0] = 64'h0000_0011_0000_0010; vec[1] = 64'h0000_0013_0000_0012;
    vec[2] = 64'h0000_0015_0000_0014; vec[3] = 64'h0000_0017_0000_0016;
    do_init(3'd1, 32'h0000_0010);
    for (int n = 0; n < 4; n++) begin
      beat(vec[n], 8'hFF);
      checks++; if (exp_data !== vec[n]) begin errors++; $display("FAIL incr_exp_beat%0d got %h exp %h", n, exp_data, vec[n]); end
    end
    checks++; if (wrd_cntr !== 8'd4) begin errors++; $display("FAIL incr_wrd_cntr got %0d exp 4", wrd_cntr); end
    checks++; if (msmatch_err !== 1'b0) begin errors++; $display("FAIL incr_msmatch got %b exp 0", msmatch_err); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL incr_err_cnt got %0d exp 0", err_cnt); end
  endtask

  task automatic test_rotl();
    do_init(3'd2, 32'h8000_0001);
    beat(64'h0000_0003_8000_0001, 8'hFF);
    beat(64'h0000_000C_0000_0006, 8'hFF);
    checks++; if (exp_data !== 64'h0000_000C_0000_0006) begin errors++; $display("FAIL rotl_exp got %h exp 0000000c00000006", exp_data); end
    checks++; if (msmatch_err !== 1'b0) begin errors++; $display("FAIL rotl_msmatch got %b exp 0", msmatch_err); end
  endtask

  task automatic test_fixed_err();
    do_init(3'd5, 32'h1122_3344);
    beat(64'h1122_3344_1122_3344, 8'hFF);
    checks++; if (msmatch_err !== 1'b0) begin errors++; $display("FAIL mode5_msmatch got %b exp 0", msmatch_err); end
    do_init(3'd0, 32'hA5A5_A5A5);
    beat(64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
    beat(64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
    checks++; if (msmatch_err !== 1'b0) begin errors++; $display("FAIL fixed_good_msmatch got %b exp 0", msmatch_err); end
    beat(64'hA5A5_A5A5_A5A5_A500, 8'hFF);
    checks++; if (msmatch_err !== 1'b1) begin errors++; $display("FAIL fixed_msmatch got %b exp 1", msmatch_err); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL fixed_err_cnt got %0d exp 1", err_cnt); end
    checks++; if (first_err_idx !== 16'd2) begin errors++; $display("FAIL fixed_first_idx got %0d exp 2", first_err_idx); end
    beat(64'h00A5_A5A5_A5A5_A5A5, 8'hFF);
    checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL fixed_err_cnt2 got %0d exp 2", err_cnt); end
    checks++; if (first_err_idx !== 16'd2) begin errors++; $display("FAIL fixed_first_idx_hold got %0d exp 2", first_err_idx); end
  endtask

  task automatic test_bvld_mask();
    do_init(3'd1, 32'h0000_0100);
    beat(64'h0000_0101_0000_0100, 8'hFF);
    beat(64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
    checks++; if (wrd_cntr !== 8'd2) begin errors++; $display("FAIL mask_zero_counted got %0d exp 2", wrd_cntr); end
    checks++; if (msmatch_err !== 1'b0) begin errors++; $display("FAIL mask_zero_msmatch got %b exp 0", msmatch_err); end
    beat(64'h0000_0105_0000_0100, 8'hFE);
    checks++; if (msmatch_err !== 1'b0) begin errors++; $display("FAIL mask_fe_msmatch got %b exp 0", msmatch_err); end
    checks++; if (exp_data !== 64'h0000_0105_0000_0104) begin errors++; $display("FAIL mask_exp_idx2 got %h exp 0000010500000104", exp_data); end
    beat(64'h0000_0000_0000_0000, 8'h00);
    beat(64'h0000_0109_0000_0108, 8'hFF);
    checks++; if (msmatch_err !== 1'b0) begin errors++; $display("FAIL mask_after_skip_msmatch got %b exp 0", msmatch_err); end
    checks++; if (wrd_cntr !== 8'd5) begin errors++; $display("FAIL mask_wrd_cntr got %0d exp 5", wrd_cntr); end
    beat(64'hFF00_010B_0000_010A, 8'h80);
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL mask_top_byte_err got %0d exp 1", err_cnt); end
    checks++; if (first_err_idx !== 16'd5) begin errors++; $display("FAIL mask_first_idx got %0d exp 5", first_err_idx); end
  endtask

  task automatic test_wrap_alt();
    do_init(3'd3, 32'h1234_5678);
    for (int n = 0; n < 260; n++) beat(64'hEDCB_A987_1234_5678, 8'hFF);
    checks++; if (wrd_cntr !== 8'd4) begin errors++; $display("FAIL alt_wrap_wrd_cntr got %0d exp 4", wrd_cntr); end
    checks++; if (msmatch_err !== 1'b0) begin errors++; $display("FAIL alt_msmatch got %b exp 0", msmatch_err); end
    wrd_cntr_rst = 1'b1;
    beat(64'hEDCB_A987_1234_5678, 8'hFF);
    wrd_cntr_rst = 1'b0;
    checks++; if (wrd_cntr !== 8'd0) begin errors++; $display("FAIL cntr_rst_wrd_cntr got %0d exp 0", wrd_cntr); end
    beat(64'hEDCB_A987_1234_5678, 8'hFF);
    checks++; if (wrd_cntr !== 8'd1) begin errors++; $display("FAIL cntr_rst_next got %0d exp 1", wrd_cntr); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL cntr_rst_err_cnt got %0d exp 0", err_cnt); end
  endtask

  task automatic test_lfsr();
    do_init(3'd4, 32'h0000_0000);
    beat(64'h8020_0003_0000_0001, 8'hFF);
    checks++; if (exp_data !== 64'h8020_0003_0000_0001) begin errors++; $display("FAIL lfsr_exp0 got %h exp 8020000300000001", exp_data); end
    beat(64'h6018_0001_C030_0002, 8'hFF);
    checks++; if (exp_data !== 64'h6018_0001_C030_0002) begin errors++; $display("FAIL lfsr_exp1 got %h exp 60180001c0300002", exp_data); end
    checks++; if (msmatch_err !== 1'b0) begin errors++; $display("FAIL lfsr_msmatch got %b exp 0", msmatch_err); end
    beat(64'h0, 8'hFF);
    checks++; if (first_err_idx !== 16'd2) begin errors++; $display("FAIL lfsr_first_idx got %0d exp 2", first_err_idx); end
    // init and a garbage beat in the same cycle: beat must be dropped
    rdata = 64'h0; rdata_bvld = 8'hFF; rdata_vld = 1'b1;
    do_init(3'd4, 32'h0000_0000);
    rdata_vld = 1'b0;
    checks++; if (msmatch_err !== 1'b0) begin errors++; $display("FAIL lfsr_init_msmatch got %b exp 0", msmatch_err); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL lfsr_init_err_cnt got %0d exp 0", err_cnt); end
    checks++; if (wrd_cntr !== 8'd0) begin errors++; $display("FAIL lfsr_init_wrd_cntr got %0d exp 0", wrd_cntr); end
    beat(64'h8020_0003_0000_0001, 8'hFF);
    checks++; if (msmatch_err !== 1'b0) begin errors++; $display("FAIL lfsr_restart_msmatch got %b exp 0", msmatch_err); end
    checks++; if (wrd_cntr !== 8'd1) begin errors++; $display("FAIL lfsr_restart_wrd_cntr got %0d exp 1", wrd_cntr); end
  endtask

  task automatic test_rst_mid();
    do_init(3'd0, 32'h5A5A_5A5A);
    beat(64'h5A5A_5A5A_5A5A_5A5A, 8'hFF);
    beat(64'h0, 8'hFF);
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL mid_err_cnt got %0d exp 1", err_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({wrd_cntr, msmatch_err, err_cnt, first_err_idx} !== 41'd0) begin errors++; $display("FAIL mid_rst_status got %h exp 0", {wrd_cntr, msmatch_err, err_cnt, first_err_idx}); end
    checks++; if (exp_data !== 64'd0) begin errors++; $display("FAIL mid_rst_exp_data got %h exp 0", exp_data); end
    beat(64'h0, 8'hFF);
    beat(64'h0, 8'hFF);
    checks++; if (wrd_cntr !== 8'd0) begin errors++; $display("FAIL post_rst_wrd_cntr got %0d exp 0", wrd_cntr); end
    checks++; if (msmatch_err !== 1'b0) begin errors++; $display("FAIL post_rst_msmatch got %b exp 0", msmatch_err); end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_incr();
    test_rotl();
    test_fixed_err();
    test_bvld_mask();
    test_wrap_alt();
    test_lfsr();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
